vdp_vram_slot_scheduler: RTL

Per-line VRAM access scheduler for the VDP. Driven by the raster timing strobes (`line_ended`, `frame_ended`, `active_frame_ended`), it divides each scanline's offscreen period into a fixed sequence of fetch slots. Slots go to the four tilemap layers, then the sprite engine. Leftover cycles go to the CPU VRAM port. It sits between the raster timing generator and the VRAM port mux.

---
 rtl/vdp_vram_slot_scheduler.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/vdp_vram_slot_scheduler.sv
// Per-line VRAM slot scheduler: layer bursts, then sprite burst, CPU on leftover cycles.
// Optional macro VDP_SCHED_CPU_RESERVE_EN reserves every 8th scheduled cycle for the CPU.
module vdp_vram_slot_scheduler #(
  parameter int LAYER_SLOTS  = 8,
  parameter int SPRITE_SLOTS = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       line_ended,
  input  logic       frame_ended,
  input  logic       active_frame_ended,
  input  logic [3:0] layer_enable,
  input  logic       cpu_req,
  input  logic       overrun_clear,
  output logic [3:0] layer_grant,
  output logic [3:0] layer_slot,
  output logic       sprite_grant,
  output logic [3:0] sprite_slot,
  output logic       cpu_ack,
  output logic       fetch_done,
  output logic       overrun
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAYER  = 2'd1,
    SPRITE = 2'd2
  } state_t;

  localparam logic [3:0] LAYER_LAST  = 4'(LAYER_SLOTS - 1);
  localparam logic [3:0] SPRITE_LAST = 4'(SPRITE_SLOTS - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] slot_q, slot_d;
  logic [3:0] en_q, en_d;
  logic       vblank_q, vblank_d;
  logic       overrun_q, overrun_d;
  logic       start_s;
  logic       reserved_cur_s;
  logic       reserved_nxt_s;
  logic       eligible_nxt_s;

  logic [3:0] layer_grant_q, layer_grant_d;
  logic [3:0] layer_slot_q, layer_slot_d;
  logic       sprite_grant_q, sprite_grant_d;
  logic [3:0] sprite_slot_q, sprite_slot_d;
  logic       cpu_ack_q, cpu_ack_d;
  logic       fetch_done_q, fetch_done_d;

`ifdef VDP_SCHED_CPU_RESERVE_EN
  logic [2:0] phase_q, phase_d;
`endif

  // Next schedule position: line strobe handling first, then slot advance.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    slot_d       = slot_q;
    en_d         = en_q;
    vblank_d     = vblank_q;
    start_s      = 1'b0;
    fetch_done_d = 1'b0;
`ifdef VDP_SCHED_CPU_RESERVE_EN
    phase_d        = phase_q + 3'd1;
    reserved_cur_s = (state_q != IDLE) && (phase_q == 3'd7);
`else
    reserved_cur_s = 1'b0;
`endif

    if (line_ended) begin
      if (active_frame_ended) begin
        vblank_d = 1'b1;
        state_d  = IDLE;
      end else if (frame_ended) begin
        vblank_d = 1'b0;
        start_s  = 1'b1;
      end else if (!vblank_q) begin
        start_s = 1'b1;
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        LAYER: begin
          // Reserved cycles freeze the burst position.
          if (reserved_cur_s) begin
            slot_d = slot_q;
          end else if (slot_q == LAYER_LAST) begin
            slot_d = 4'd0;
            if (idx_q == 2'd3) begin
              state_d = SPRITE;
            end else begin
              idx_d = idx_q + 2'd1;
            end
          end else begin
            slot_d = slot_q + 4'd1;
          end
        end
        SPRITE: begin
          if (reserved_cur_s) begin
            slot_d = slot_q;
          end else if (slot_q == SPRITE_LAST) begin
            state_d      = IDLE;
            slot_d       = 4'd0;
            fetch_done_d = 1'b1;
          end else begin
            slot_d = slot_q + 4'd1;
          end
        end
        default: begin
          state_d = IDLE;
          slot_d  = 4'd0;
          idx_d   = 2'd0;
        end
      endcase
    end

    if (start_s) begin
      state_d = LAYER;
      idx_d   = 2'd0;
      slot_d  = 4'd0;
      en_d    = layer_enable;
`ifdef VDP_SCHED_CPU_RESERVE_EN
      phase_d = 3'd0;
`endif
    end else begin
      en_d = en_q;
    end

    if (overrun_clear) begin
      overrun_d = 1'b0;
    end else if (line_ended && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Output decode from the next position so every output is a flop.
  always_comb begin
`ifdef VDP_SCHED_CPU_RESERVE_EN
    reserved_nxt_s = (state_d != IDLE) && (phase_d == 3'd7);
`else
    reserved_nxt_s = 1'b0;
`endif
    layer_grant_d  = 4'd0;
    layer_slot_d   = 4'd0;
    sprite_grant_d = 1'b0;
    sprite_slot_d  = 4'd0;

    if ((state_d == LAYER) && !reserved_nxt_s && en_d[idx_d]) begin
      layer_grant_d = 4'b0001 << idx_d;
      layer_slot_d  = slot_d;
    end else begin
      layer_grant_d = 4'd0;
      layer_slot_d  = 4'd0;
    end

    if ((state_d == SPRITE) && !reserved_nxt_s) begin
      sprite_grant_d = 1'b1;
      sprite_slot_d  = slot_d;
    end else begin
      sprite_grant_d = 1'b0;
      sprite_slot_d  = 4'd0;
    end

    eligible_nxt_s = (state_d == IDLE) ||
                     ((state_d == LAYER) && !en_d[idx_d]) ||
                     reserved_nxt_s;
    cpu_ack_d = cpu_req && eligible_nxt_s;
  end

  // Schedule state and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      idx_q          <= 2'd0;
      slot_q         <= 4'd0;
      en_q           <= 4'd0;
      vblank_q       <= 1'b0;
      overrun_q      <= 1'b0;
      layer_grant_q  <= 4'd0;
      layer_slot_q   <= 4'd0;
      sprite_grant_q <= 1'b0;
      sprite_slot_q  <= 4'd0;
      cpu_ack_q      <= 1'b0;
      fetch_done_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      slot_q         <= slot_d;
      en_q           <= en_d;
      vblank_q       <= vblank_d;
      overrun_q      <= overrun_d;
      layer_grant_q  <= layer_grant_d;
      layer_slot_q   <= layer_slot_d;
      sprite_grant_q <= sprite_grant_d;
      sprite_slot_q  <= sprite_slot_d;
      cpu_ack_q      <= cpu_ack_d;
      fetch_done_q   <= fetch_done_d;
    end
  end

`ifdef VDP_SCHED_CPU_RESERVE_EN
  // Free-running reservation phase, realigned at every schedule start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= 3'd0;
    end else begin
      phase_q <= phase_d;
    end
  end
`endif

  assign layer_grant  = layer_grant_q;
  assign layer_slot   = layer_slot_q;
  assign sprite_grant = sprite_grant_q;
  assign sprite_slot  = sprite_slot_q;
  assign cpu_ack      = cpu_ack_q;
  assign fetch_done   = fetch_done_q;
  assign overrun      = overrun_q;

endmodule
